// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B, LSB first) built from one full-subtractor cell and a
// borrow flip-flop. Parallel operands in, parallel difference out, each bit also streamed out.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             bit_d,
  output logic             bit_valid
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, b_sr_q, res_q, diff_q;
  logic               w_q, borrow_q;
  logic [CntW-1:0]    cnt_q;

  logic               ai, bi, d, w_next, last;
  logic [WIDTH-1:0]   res_next;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign ai       = a_sr_q[0];
  assign bi       = b_sr_q[0];
  assign d        = ai ^ bi ^ w_q;
  assign w_next   = (~ai & bi) | (~(ai ^ bi) & w_q);
  assign last     = (cnt_q == CntW'(WIDTH - 1));
  assign res_next = {d, res_q[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend only on registered state, never directly on start/a/b.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    bit_valid = (state_q == StRun);
    bit_d     = (state_q == StRun) & d;
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;

  // Datapath: operand shifters, result shifter, borrow FF, bit counter and held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      w_q      <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sr_q <= a;
            b_sr_q <= b;
            w_q    <= 1'b0;
            cnt_q  <= '0;
          end
        end
        StRun: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          res_q  <= res_next;
          w_q    <= w_next;
          cnt_q  <= cnt_q + CntW'(1);
          if (last) begin
            diff_q   <= res_next;
            borrow_q <= w_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 bit-stream/handshake checks plus an exhaustive
// WIDTH=4 sweep against a parallel subtraction model.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8, busy8, done8, borrow8, bit_d8, bit_valid8;
  logic [7:0] a8, b8, diff8;

  logic       start4, busy4, done4, borrow4, bit_d4, bit_valid4;
  logic [3:0] a4, b4, diff4;

  int passed = 0;
  int total  = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (borrow8),
    .bit_d      (bit_d8),
    .bit_valid  (bit_valid8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .a          (a4),
    .b          (b4),
    .busy       (busy4),
    .done       (done4),
    .diff       (diff4),
    .borrow_out (borrow4),
    .bit_d      (bit_d4),
    .bit_valid  (bit_valid4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation starting from an IDLE cycle; leaves the bench in the following IDLE cycle.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] expd,
                      input logic expb, input bit hold);
    a8     = av;
    b8     = bv;
    start8 = 1'b1;
    tick();
    if (!hold) start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("run_busy", 32'(busy8), 1);
      check("run_valid", 32'(bit_valid8), 1);
      check("run_bit", 32'(bit_d8), 32'(expd[i]));
      check("run_nodone", 32'(done8), 0);
      if (hold) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      tick();
    end
    check("done_pulse", 32'(done8), 1);
    check("done_busy", 32'(busy8), 1);
    check("done_novalid", 32'(bit_valid8), 0);
    check("diff", 32'(diff8), 32'(expd));
    check("borrow", 32'(borrow8), 32'(expb));
    tick();
    check("idle_busy", 32'(busy8), 0);
    check("idle_done", 32'(done8), 0);
    check("diff_held", 32'(diff8), 32'(expd));
  endtask

  initial begin
    logic [4:0] model;
    bit         seen_done;

    rst_n  = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    a8     = '0;
    b8     = '0;
    a4     = '0;
    b4     = '0;
    #12;
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_diff", 32'(diff8), 0);
    check("rst_borrow", 32'(borrow8), 0);
    check("rst_bit", 32'(bit_d8), 0);
    check("rst_valid", 32'(bit_valid8), 0);
    check("rst_busy4", 32'(busy4), 0);
    rst_n = 1'b1;
    tick();

    run8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run8(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    run8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run8(8'h80, 8'h80, 8'h00, 1'b0, 1'b0);

    // start held through RUN with scrambled operands, then still high in the next IDLE cycle.
    run8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b1);
    run8(8'h20, 8'h30, 8'hF0, 1'b1, 1'b0);

    // Abort in the 4th RUN cycle, between edges.
    a8     = 8'h77;
    b8     = 8'h22;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    check("mid_valid", 32'(bit_valid8), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 0);
    check("abort_valid", 32'(bit_valid8), 0);
    check("abort_diff", 32'(diff8), 0);
    check("abort_borrow", 32'(borrow8), 0);
    check("abort_done", 32'(done8), 0);
    #1 rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 0);
    run8(8'h55, 8'h11, 8'h44, 1'b0, 1'b0);

    // Exhaustive WIDTH=4 sweep, start held high so operations run back-to-back.
    start4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i);
        b4 = 4'(j);
        tick();
        for (int k = 0; k < 10 && !done4; k++) tick();
        model = {1'b0, a4} - {1'b0, b4};
        if (!done4) begin
          check("w4_timeout", 32'(done4), 1);
        end else begin
          check("w4_diff", 32'(diff4), 32'(model[3:0]));
          check("w4_borrow", 32'(borrow4), 32'(model[4]));
        end
        tick();
      end
    end
    start4 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
